// File: rtl/game_pkg.sv
// Shared encodings and helpers for lane_game_core: FSM states, LFSR seed/taps, saturating score math.
// Pure declarations, no state, no latency, no flow control.
package game_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: feedback bits 0,2,3,5 realise taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [31:0] sat_add_sub(input logic [31:0] base,
                                              input logic [3:0]  up,
                                              input logic [3:0]  down,
                                              input logic [31:0] max_val);
    logic [33:0] sum;
    sum = {2'b00, base} + {30'd0, up};
    if (sum < {30'd0, down}) return 32'd0;
    sum = sum - {30'd0, down};
    if (sum > {2'b00, max_val}) return max_val;
    return sum[31:0];
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/lane_tracker.sv
// One lane: tile position/active, hit/miss/stray detection against the pre-move y, in_zone.
// Registers update one clk after press/tick/spawn; no backpressure, events are flags for the top.
module lane_tracker #(
  parameter int Y_W      = 10,
  parameter int SCREEN_H = 480,
  parameter int ZONE_LO  = 380,
  parameter int ZONE_HI  = 420
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           play,
  input  logic           tick,
  input  logic           press,
  input  logic           spawn,
  input  logic [Y_W-1:0] step,
  output logic [Y_W-1:0] tile_y,
  output logic           tile_active,
  output logic           in_zone,
  output logic           hit,
  output logic           miss,
  output logic           stray
);

  logic [Y_W:0] y_next;

  assign in_zone = tile_active && (tile_y >= Y_W'(ZONE_LO)) && (tile_y <= Y_W'(ZONE_HI));
  assign hit     = play && press && in_zone;
  assign stray   = play && press && !in_zone;
  assign y_next  = {1'b0, tile_y} + {1'b0, step};
  assign miss    = play && tick && tile_active && !hit && (y_next >= (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_y      <= '0;
      tile_active <= 1'b0;
    end else if (clear) begin
      tile_y      <= '0;
      tile_active <= 1'b0;
    end else if (play) begin
      // The spawner only picks lanes that are idle and not hit/missed, so spawn never collides.
      if (spawn) begin
        tile_y      <= '0;
        tile_active <= 1'b1;
      end else if (hit || miss) begin
        tile_y      <= '0;
        tile_active <= 1'b0;
      end else if (tick && tile_active) begin
        tile_y <= y_next[Y_W-1:0];
      end
    end
  end

endmodule

// File: rtl/lane_game_core.sv
// lane_game_core: N-lane falling-tile game engine (FSM, LFSR spawner, scoring); GAME_SPEED_RAMP_EN adds a speed level.
// State and pulses update one clk after the inputs; no backpressure, buttons are sampled every cycle.
module lane_game_core
  import game_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int Y_W          = 10,
  parameter int SCREEN_H     = 480,
  parameter int ZONE_LO      = 380,
  parameter int ZONE_HI      = 420,
  parameter int FRAME_DIV    = 833334,
  parameter int SPAWN_FRAMES = 60,
  parameter int FALL_STEP    = 4,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NUM_LANES-1:0]     btn,
  output logic [NUM_LANES*Y_W-1:0] tile_y,
  output logic [NUM_LANES-1:0]     tile_active,
  output logic [NUM_LANES-1:0]     in_zone,
  output logic [SCORE_W-1:0]       score,
  output logic [7:0]               combo,
  output logic [2:0]               lives,
  output logic [1:0]               state,
  output logic                     frame_tick,
  output logic                     hit_pulse,
  output logic                     miss_pulse
);

  localparam int LW = $clog2(NUM_LANES);
  localparam int FW = $clog2(FRAME_DIV + 1);
  localparam int SW = $clog2(SPAWN_FRAMES + 1);
  localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

  logic [FW-1:0]        frame_cnt;
  logic [SW-1:0]        spawn_cnt;
  logic [15:0]          lfsr;
  logic [NUM_LANES-1:0] btn_prev;
  logic [NUM_LANES-1:0] press;
  logic [NUM_LANES-1:0] hit;
  logic [NUM_LANES-1:0] miss;
  logic [NUM_LANES-1:0] stray;
  logic [NUM_LANES-1:0] free;
  logic [NUM_LANES-1:0] spawn_vec;
  logic [LW-1:0]        lane_a;
  logic [LW-1:0]        lane_b;
  logic                 play;
  logic                 spawn_due;
  logic [Y_W-1:0]       step;
  logic [3:0]           h_cnt;
  logic [3:0]           m_cnt;
  logic [8:0]           combo_sum;

  assign frame_tick = (frame_cnt == FW'(FRAME_DIV - 1));
  // A start pulse overrides this cycle's play so the restart is clean.
  assign play       = (state == ST_PLAY) && !start;
  assign press      = btn & ~btn_prev;
  assign spawn_due  = play && frame_tick && (spawn_cnt == SW'(SPAWN_FRAMES - 1));
  assign lane_a     = lfsr[LW-1:0];
  assign lane_b     = lane_a + LW'(1);
  assign free       = ~tile_active & ~hit & ~miss;
  assign h_cnt      = popcount8(8'(hit));
  assign m_cnt      = popcount8(8'(miss));
  assign combo_sum  = {1'b0, combo} + {5'b00000, h_cnt};

  always_comb begin
    spawn_vec = '0;
    if (spawn_due) begin
      if (free[lane_a])      spawn_vec[lane_a] = 1'b1;
      else if (free[lane_b]) spawn_vec[lane_b] = 1'b1;
    end
  end

`ifdef GAME_SPEED_RAMP_EN
  localparam int STEP_MAX = 2 * FALL_STEP;
  logic [3:0]   level;
  logic [3:0]   hit_acc;
  logic [4:0]   acc_sum;
  logic [Y_W:0] step_sum;

  assign acc_sum  = {1'b0, hit_acc} + {1'b0, h_cnt};
  assign step_sum = (Y_W+1)'(FALL_STEP) + (Y_W+1)'(level);
  assign step     = (step_sum > (Y_W+1)'(STEP_MAX)) ? Y_W'(STEP_MAX) : step_sum[Y_W-1:0];

  // hit_acc wraps every 16 hits; at most 8 hits per cycle so one wrap per cycle suffices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= 4'd0;
      hit_acc <= 4'd0;
    end else if (start) begin
      level   <= 4'd0;
      hit_acc <= 4'd0;
    end else if (play) begin
      hit_acc <= acc_sum[3:0];
      if (acc_sum[4] && level != 4'd15) level <= level + 4'd1;
    end
  end
`else
  assign step = Y_W'(FALL_STEP);
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_tracker #(
      .Y_W      (Y_W),
      .SCREEN_H (SCREEN_H),
      .ZONE_LO  (ZONE_LO),
      .ZONE_HI  (ZONE_HI)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (start),
      .play        (play),
      .tick        (frame_tick),
      .press       (press[i]),
      .spawn       (spawn_vec[i]),
      .step        (step),
      .tile_y      (tile_y[i*Y_W +: Y_W]),
      .tile_active (tile_active[i]),
      .in_zone     (in_zone[i]),
      .hit         (hit[i]),
      .miss        (miss[i]),
      .stray       (stray[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt  <= '0;
      lfsr       <= LFSR_SEED;
      btn_prev   <= '0;
      state      <= ST_IDLE;
      score      <= '0;
      combo      <= 8'd0;
      lives      <= 3'd0;
      spawn_cnt  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      frame_cnt  <= frame_tick ? '0 : frame_cnt + FW'(1);
      lfsr       <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
      btn_prev   <= btn;
      hit_pulse  <= |hit;
      miss_pulse <= |miss;
      if (start) begin
        state     <= ST_PLAY;
        score     <= '0;
        combo     <= 8'd0;
        lives     <= 3'(LIVES);
        spawn_cnt <= '0;
      end else if (state == ST_PLAY) begin
        // Registered on the lives value, so OVER appears one cycle after lives reads 0.
        if (lives == 3'd0) state <= ST_OVER;
        score <= SCORE_W'(sat_add_sub(32'(score), h_cnt, m_cnt, SCORE_MAX));
        if (m_cnt != 4'd0 || |stray) combo <= 8'd0;
        else if (combo_sum > 9'd255) combo <= 8'hFF;
        else combo <= combo_sum[7:0];
        if (m_cnt != 4'd0 && lives != 3'd0) lives <= lives - 3'd1;
        if (frame_tick) spawn_cnt <= (spawn_cnt == SW'(SPAWN_FRAMES - 1)) ? '0 : spawn_cnt + SW'(1);
      end
    end
  end

endmodule
